// File: rtl/spi_slave_if.sv
// -----------------------------------------------------------------------------
// spi_slave_if
// Bundles the SPI pins and the parallel word interface of spi_slave.
//   sclk, ss_n, mosi : SPI pins driven by the master (asynchronous to the core)
//   miso             : serial data returned to the master
//   tx_data          : word to transmit, captured at each load point
//   tx_load          : one-cycle pulse when tx_data has been captured
//   rx_data          : last complete received word
//   rx_valid         : one-cycle pulse when rx_data updates
//   busy             : high while the slave is selected
// Modports: slave (the spi_slave core), master (the environment driving it).
// -----------------------------------------------------------------------------
interface spi_slave_if #(
    parameter int BITS = 8
);
    logic            sclk;
    logic            ss_n;
    logic            mosi;
    logic            miso;
    logic [BITS-1:0] tx_data;
    logic            tx_load;
    logic [BITS-1:0] rx_data;
    logic            rx_valid;
    logic            busy;

    modport slave (
        input  sclk, ss_n, mosi, tx_data,
        output miso, tx_load, rx_data, rx_valid, busy
    );

    modport master (
        output sclk, ss_n, mosi, tx_data,
        input  miso, tx_load, rx_data, rx_valid, busy
    );
endinterface

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
// SPI mode 0 (CPOL=0, CPHA=0, MSB first) slave with BITS-wide words, running
// entirely in the CLOCK_50 domain. The SPI pins are oversampled through
// synchronizers; edges are found by comparing the synchronized value against
// one further registered copy.
//   CLOCK_50 : system clock, rising edge
//   reset    : synchronous, active-high
//   bus      : spi_slave_if.slave (SPI pins plus tx/rx word handshake)
// -----------------------------------------------------------------------------
module spi_slave #(
    parameter int BITS = 8
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    spi_slave_if.slave bus
);
    localparam int CNT_W = $clog2(BITS + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state, state_next;

    // [0] first synchronizer flop, [1] synchronized value, [2] delayed copy
    logic [2:0]       sclk_sync;
    logic [2:0]       ss_sync;
    logic [1:0]       mosi_sync;

    logic [BITS-1:0]  tx_shift;
    logic [BITS-1:0]  rx_shift;
    logic [BITS-1:0]  rx_next;
    logic [BITS-1:0]  rx_word;
    logic [CNT_W-1:0] bit_cnt;
    logic             reload_pend;   // next sclk fall reloads instead of shifting
    logic             rx_pulse;
    logic             load_pulse;

    logic sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic select, deselect, shift_in, shift_out, word_done;

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign ss_fall   = ~ss_sync[1] & ss_sync[2];
    assign ss_rise   = ss_sync[1] & ~ss_sync[2];

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle decisions
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_next = state;
        select     = 1'b0;
        deselect   = 1'b0;
        unique case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_next = ACTIVE;
                    select     = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_next = IDLE;
                    deselect   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // sclk edges only count while selected and not being deselected. In IDLE a
    // coincident ss_n fall wins automatically because state is still IDLE.
    assign shift_in  = (state == ACTIVE) && !ss_rise && sclk_rise;
    assign shift_out = (state == ACTIVE) && !ss_rise && sclk_fall;
    assign rx_next   = {rx_shift[BITS-2:0], mosi_sync[1]};
    assign word_done = (bit_cnt == CNT_W'(BITS - 1));

    // Synchronizers and datapath
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            // Synchronizers reset to the idle pin levels so that releasing
            // reset with the bus idle produces no spurious edge.
            sclk_sync   <= 3'b000;
            ss_sync     <= 3'b111;
            mosi_sync   <= 2'b00;
            tx_shift    <= '0;
            rx_shift    <= '0;
            rx_word     <= '0;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
            rx_pulse    <= 1'b0;
            load_pulse  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here sees the pre-edge value of every other register.
            sclk_sync  <= {sclk_sync[1:0], bus.sclk};
            ss_sync    <= {ss_sync[1:0], bus.ss_n};
            mosi_sync  <= {mosi_sync[0], bus.mosi};
            rx_pulse   <= 1'b0;
            load_pulse <= 1'b0;

            if (select) begin
                tx_shift    <= bus.tx_data;
                load_pulse  <= 1'b1;
                bit_cnt     <= '0;
                reload_pend <= 1'b0;
            end else if (deselect) begin
                // Partial word is dropped; rx_word keeps the last full word.
                bit_cnt     <= '0;
                reload_pend <= 1'b0;
            end else if (shift_in) begin
                rx_shift <= rx_next;
                if (word_done) begin
                    rx_word     <= rx_next;
                    rx_pulse    <= 1'b1;
                    bit_cnt     <= '0;
                    reload_pend <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end else if (shift_out) begin
                if (reload_pend) begin
                    tx_shift    <= bus.tx_data;
                    load_pulse  <= 1'b1;
                    reload_pend <= 1'b0;
                end else begin
                    tx_shift <= {tx_shift[BITS-2:0], 1'b0};
                end
            end
        end
    end

    assign bus.busy     = (state == ACTIVE);
    assign bus.miso     = (state == ACTIVE) & tx_shift[BITS-1];
    assign bus.rx_data  = rx_word;
    assign bus.rx_valid = rx_pulse;
    assign bus.tx_load  = load_pulse;

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
// Drives an 8-bit and a 16-bit spi_slave from the same SPI pins. The master
// sends a bit stream; the expected received words, returned miso bits,
// tx_load counts and rx_valid timing are computed from the bit stream and the
// word lists each slave is offered.
// -----------------------------------------------------------------------------
module tb_spi_slave;
    localparam int HALF = 8;       // sclk half period in CLOCK_50 cycles

    logic        clk = 1'b0;
    logic        reset;
    logic        sclk;
    logic        ss_n;
    logic        mosi;
    logic [7:0]  tx_data8;
    logic [15:0] tx_data16;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    spi_slave_if #(.BITS(8))  bus8();
    spi_slave_if #(.BITS(16)) bus16();

    assign bus8.sclk     = sclk;
    assign bus8.ss_n     = ss_n;
    assign bus8.mosi     = mosi;
    assign bus8.tx_data  = tx_data8;
    assign bus16.sclk    = sclk;
    assign bus16.ss_n    = ss_n;
    assign bus16.mosi    = mosi;
    assign bus16.tx_data = tx_data16;

    spi_slave #(.BITS(8)) dut8 (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus8)
    );

    spi_slave #(.BITS(16)) dut16 (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus / model state (written by the main initial block only)
    logic [15:0] s8_words[$];
    logic [15:0] s16_words[$];
    bit          mosi_bits[$];
    bit          miso8_bits[$];
    bit          miso16_bits[$];
    int          rise_cyc[$];
    int          base_txl8 = 0, base_txl16 = 0, base_rx8 = 0, base_rx16 = 0;
    logic [15:0] prev_rx8, prev_rx16;

    // Observed events (written by the monitors only)
    logic [15:0] rx8_got[$];
    logic [15:0] rx16_got[$];
    int          rv8_cyc[$];
    int          rv16_cyc[$];
    int          txl8_cnt = 0, txl16_cnt = 0;

    function automatic logic [15:0] word_at(input int w, input int idx);
        if (w == 8) return (idx >= 0 && idx < s8_words.size()) ? s8_words[idx] : 16'h0;
        return (idx >= 0 && idx < s16_words.size()) ? s16_words[idx] : 16'h0;
    endfunction

    function automatic logic [15:0] mosi_word(input int w, input int k);
        logic [15:0] v;
        v = '0;
        for (int b = 0; b < w; b++) v = {v[14:0], mosi_bits[k*w+b]};
        return v;
    endfunction

    // Monitors: record rx words and tx_load pulses; present the next offered
    // word on tx_data once the current one has been captured.
    always @(negedge clk) begin
        if (bus8.rx_valid) begin
            rx8_got.push_back(16'(bus8.rx_data));
            rv8_cyc.push_back(cyc);
        end
        if (bus8.tx_load) txl8_cnt <= txl8_cnt + 1;
        tx_data8 <= 8'(word_at(8, txl8_cnt - base_txl8 + int'(bus8.tx_load)));
    end

    always @(negedge clk) begin
        if (bus16.rx_valid) begin
            rx16_got.push_back(bus16.rx_data);
            rv16_cyc.push_back(cyc);
        end
        if (bus16.tx_load) txl16_cnt <= txl16_cnt + 1;
        tx_data16 <= word_at(16, txl16_cnt - base_txl16 + int'(bus16.tx_load));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic load_mosi(input logic [15:0] value, input int n);
        for (int b = n - 1; b >= 0; b--) mosi_bits.push_back(value[b]);
    endtask

    task automatic snap();
        base_txl8  = txl8_cnt;
        base_txl16 = txl16_cnt;
        base_rx8   = rx8_got.size();
        base_rx16  = rx16_got.size();
        prev_rx8   = 16'(bus8.rx_data);
        prev_rx16  = bus16.rx_data;
    endtask

    // Master: sends mosi_bits[0..nbits-1]; the last sclk fall coincides with
    // the ss_n release. With reset_at > 0 the transfer is cut by a reset
    // after that many rising edges (returns with reset still high).
    task automatic spi_xfer(input int nbits, input int reset_at);
        miso8_bits.delete();
        miso16_bits.delete();
        rise_cyc.delete();
        @(negedge clk);
        ss_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            mosi = mosi_bits[i];
            repeat (HALF) @(negedge clk);
            miso8_bits.push_back(bus8.miso);
            miso16_bits.push_back(bus16.miso);
            sclk = 1'b1;
            rise_cyc.push_back(cyc);
            repeat (HALF) @(negedge clk);
            if (reset_at == i + 1) begin
                reset = 1'b1;
                sclk  = 1'b0;
                ss_n  = 1'b1;
                mosi  = 1'b0;
                @(negedge clk);
                return;
            end
            if (i == nbits - 1) ss_n = 1'b1;
            sclk = 1'b0;
        end
        mosi = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic check_dut(input int w, input int nbits);
        logic [15:0] got[$];
        int          rvc[$];
        bit          mb[$];
        int          base_rx, txl, base_txl, nwords, mism;
        logic [15:0] exp_rx, cur_rx, wrd;
        logic        cur_busy, cur_miso;
        if (w == 8) begin
            got = rx8_got; rvc = rv8_cyc; mb = miso8_bits;
            base_rx = base_rx8; txl = txl8_cnt; base_txl = base_txl8;
            exp_rx = prev_rx8; cur_rx = 16'(bus8.rx_data);
            cur_busy = bus8.busy; cur_miso = bus8.miso;
        end else begin
            got = rx16_got; rvc = rv16_cyc; mb = miso16_bits;
            base_rx = base_rx16; txl = txl16_cnt; base_txl = base_txl16;
            exp_rx = prev_rx16; cur_rx = bus16.rx_data;
            cur_busy = bus16.busy; cur_miso = bus16.miso;
        end
        nwords = nbits / w;
        check($sformatf("rx_count_w%0d", w), 32'(got.size() - base_rx), 32'(nwords));
        for (int k = 0; k < nwords; k++) begin
            exp_rx = mosi_word(w, k);
            if (base_rx + k < got.size()) begin
                check($sformatf("rx_word_w%0d[%0d]", w, k), 32'(got[base_rx+k]), 32'(exp_rx));
                check($sformatf("rv_latency_w%0d[%0d]", w, k),
                      32'(rvc[base_rx+k] - rise_cyc[k*w+w-1]), 32'd3);
            end
        end
        check($sformatf("tx_loads_w%0d", w), 32'(txl - base_txl), 32'(1 + (nbits - 1) / w));
        mism = 0;
        for (int i = 0; i < nbits; i++) begin
            wrd = word_at(w, i / w);
            if (mb[i] !== wrd[w-1-(i%w)]) mism++;
        end
        check($sformatf("miso_stream_w%0d", w), 32'(mism), 32'd0);
        check($sformatf("rx_hold_w%0d", w), 32'(cur_rx), 32'(exp_rx));
        check($sformatf("busy_after_w%0d", w), 32'(cur_busy), 32'd0);
        check($sformatf("miso_after_w%0d", w), 32'(cur_miso), 32'd0);
    endtask

    task automatic check_all(input int nbits);
        check_dut(8, nbits);
        check_dut(16, nbits);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rx_data8"},   32'(bus8.rx_data),   32'd0);
        check({tag, "_rx_valid8"},  32'(bus8.rx_valid),  32'd0);
        check({tag, "_tx_load8"},   32'(bus8.tx_load),   32'd0);
        check({tag, "_busy8"},      32'(bus8.busy),      32'd0);
        check({tag, "_miso8"},      32'(bus8.miso),      32'd0);
        check({tag, "_rx_data16"},  32'(bus16.rx_data),  32'd0);
        check({tag, "_rx_valid16"}, 32'(bus16.rx_valid), 32'd0);
        check({tag, "_tx_load16"},  32'(bus16.tx_load),  32'd0);
        check({tag, "_busy16"},     32'(bus16.busy),     32'd0);
        check({tag, "_miso16"},     32'(bus16.miso),     32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nbits;
        int hi;
        int rx8_before, rx16_before;

        reset = 1'b1;
        sclk  = 1'b0;
        ss_n  = 1'b1;
        mosi  = 1'b0;
        repeat (4) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Single word: slave offers 3C, master sends A5
        s8_words = '{16'h003C};
        s16_words = '{16'h1234};
        mosi_bits.delete();
        load_mosi(16'h00A5, 8);
        snap();
        spi_xfer(8, 0);
        check_all(8);

        // Two words without releasing ss_n: AA then BB offered, 11 22 sent
        s8_words = '{16'h00AA, 16'h00BB};
        s16_words = '{16'hC3E1};
        mosi_bits.delete();
        load_mosi(16'h1122, 16);
        snap();
        spi_xfer(16, 0);
        check_all(16);

        // BEEF both ways on the 16-bit slave
        s8_words = '{16'h0012, 16'h0034};
        s16_words = '{16'hBEEF};
        mosi_bits.delete();
        load_mosi(16'hBEEF, 16);
        snap();
        spi_xfer(16, 0);
        check_all(16);

        // Abort after 5 bits of FF
        s8_words = '{16'h0096};
        s16_words = '{16'h7E81};
        mosi_bits.delete();
        load_mosi(16'h00FF, 8);
        snap();
        spi_xfer(5, 0);
        check_all(5);

        // Reset at bit 4, then a full 5A transfer
        s8_words = '{16'h00C7};
        s16_words = '{16'h5555};
        mosi_bits.delete();
        load_mosi(16'h0033, 8);
        snap();
        spi_xfer(8, 4);
        check_zero("midreset");
        reset = 1'b0;
        repeat (6) @(negedge clk);
        s8_words = '{16'h0081};
        s16_words = '{16'h0F0F};
        mosi_bits.delete();
        load_mosi(16'h005A, 8);
        snap();
        spi_xfer(8, 0);
        check_all(8);

        // sclk toggling while deselected
        snap();
        rx8_before  = rx8_got.size();
        rx16_before = rx16_got.size();
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            sclk = ~sclk;
            mosi = 1'($urandom);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (bus8.miso || bus16.miso || bus8.busy || bus16.busy) hi++;
            end
        end
        mosi = 1'b0;
        repeat (6) @(negedge clk);
        check("idle_rx8",      32'(rx8_got.size() - rx8_before),   32'd0);
        check("idle_rx16",     32'(rx16_got.size() - rx16_before), 32'd0);
        check("idle_txload8",  32'(txl8_cnt - base_txl8),          32'd0);
        check("idle_txload16", 32'(txl16_cnt - base_txl16),        32'd0);
        check("idle_miso_busy", 32'(hi), 32'd0);

        // Random transfers of arbitrary length (complete and partial words)
        for (int t = 0; t < 6; t++) begin
            nbits = int'($urandom_range(40, 1));
            s8_words.delete();
            s16_words.delete();
            mosi_bits.delete();
            for (int i = 0; i < 6; i++) begin
                s8_words.push_back(16'($urandom_range(255, 0)));
                s16_words.push_back(16'($urandom));
            end
            for (int i = 0; i < nbits; i++) mosi_bits.push_back(1'($urandom));
            snap();
            spi_xfer(nbits, 0);
            check_all(nbits);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
